// File: rtl/matrix_pkg.sv
// Shared constants and types for the matrix multiplier result path.
package matrix_pkg;

  localparam int unsigned MATRIX_MEM_DEPTH  = 1024;
  localparam int unsigned MATRIX_MEM_WIDTH  = 32;
  localparam int unsigned MATRIX_ADDR_WIDTH = $clog2(MATRIX_MEM_DEPTH);
  localparam int unsigned WRITER_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } writer_state_t;

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO with a combinational head; pop when full frees the slot for a same-cycle push.
module stream_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH-1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/matrix_stream_writer.sv
// Streams result RAM C words 0..len-1 onto an AXI-Stream master through a credit-limited prefetch FIFO.
module matrix_stream_writer
  import matrix_pkg::*;
#(
  parameter int unsigned MEM_DEPTH  = MATRIX_MEM_DEPTH,
  parameter int unsigned DATA_WIDTH = MATRIX_MEM_WIDTH,
  parameter int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_words,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  M_AXIS_VALID,
  input  logic                  M_AXIS_READY,
  output logic [DATA_WIDTH-1:0] M_AXIS_DATA,
  output logic                  M_AXIS_LAST
);

  localparam int unsigned CNT_W = $clog2(WRITER_FIFO_DEPTH+1);
  localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [CNT_W:0] CREDITS = (CNT_W+1)'(WRITER_FIFO_DEPTH);

  writer_state_t state, state_next;

  logic [ADDR_WIDTH:0]   len, rd_idx, beat_idx;
  logic [1:0]            rd_pend;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W:0]        credit_used;
  logic                  fifo_empty, fifo_full;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  issue, fire, last_beat;

  // Reads in flight occupy FIFO credit until their data lands two edges later.
  assign credit_used = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(rd_pend[0]) + (CNT_W+1)'(rd_pend[1]);
  assign issue       = (state == STREAM) && (rd_idx < len) && (credit_used < CREDITS) && !fifo_full;
  assign fire        = M_AXIS_VALID && M_AXIS_READY;
  assign last_beat   = (beat_idx == len - 1'b1);

  assign M_AXIS_VALID = !fifo_empty;
  assign M_AXIS_DATA  = fifo_empty ? '0 : fifo_head;
  assign M_AXIS_LAST  = M_AXIS_VALID && last_beat;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (num_words == '0) ? DONE : STREAM;
      STREAM:  if (fire && last_beat) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      STREAM:  busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      len         <= '0;
      rd_idx      <= '0;
      beat_idx    <= '0;
      mem_address <= '0;
      rd_pend     <= '0;
    end else begin
      rd_pend <= {rd_pend[0], issue};
      if (state == IDLE && start && num_words != '0) begin
        len      <= (num_words > MAX_LEN) ? MAX_LEN : num_words;
        rd_idx   <= '0;
        beat_idx <= '0;
      end
      if (issue) begin
        mem_address <= rd_idx[ADDR_WIDTH-1:0];
        rd_idx      <= rd_idx + 1'b1;
      end
      if (fire) beat_idx <= beat_idx + 1'b1;
    end
  end

  stream_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (WRITER_FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RESET),
    .push      (rd_pend[1]),
    .push_data (mem_read_data),
    .pop       (fire),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: doc/matrix_stream_writer.md
Name: matrix_stream_writer

Overview:
- Downstream output stage for the matrix multiplier.
- Once the product matrix is complete in result RAM C, this block reads RAM C sequentially from address 0 and emits each 32-bit word on an AXI-Stream master.
- It asserts LAST on the final word and absorbs back-pressure from M_AXIS_READY using an internal 4-entry prefetch FIFO.

Parameters:
MEM_DEPTH, 1024, words in result RAM; maximum stream length
DATA_WIDTH, 32, RAM and stream word width
ADDR_WIDTH, $clog2(MEM_DEPTH), RAM address width

Ports:
CLK  in  1  system clock; all logic rising-edge
RESET  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: begin streaming num_words words
num_words  in  ADDR_WIDTH+1  word count (0..MEM_DEPTH), sampled with start
busy  out  1  high from accepted start until final beat handshake
done  out  1  one-cycle pulse after final beat (or immediately for num_words=0)
mem_address  out  ADDR_WIDTH  registered read address to RAM C
mem_read_data  in  DATA_WIDTH  RAM C read data, valid one cycle after address is sampled
M_AXIS_VALID  out  1  stream valid
M_AXIS_READY  in  1  stream ready
M_AXIS_DATA  out  DATA_WIDTH  stream data
M_AXIS_LAST  out  1  high with final word only

Behaviour:
- Clock and reset: one clock, CLK. RESET is asynchronous and active-high.
- Reset values: all outputs 0 (busy, done, mem_address, M_AXIS_VALID, M_AXIS_DATA, M_AXIS_LAST). FIFO empty, counters 0, state IDLE.
- RAM read latency: the address register updates at edge k, the RAM samples it at edge k+1, and the data is pushed into the FIFO at edge k+2.
- States:
  - IDLE: start=1 with num_words>0 -> STREAM; latch len=min(num_words, MEM_DEPTH), rd_idx=0, beat_idx=0, busy=1.
  - IDLE: start=1 with num_words=0 -> DONE; no beats emitted.
  - STREAM: each cycle a read is issued when rd_idx<len and fifo_count+inflight<4. mem_address<=rd_idx, rd_idx++, inflight++.
  - STREAM: returning data is pushed into the FIFO; inflight decrements on push.
  - STREAM: M_AXIS_VALID = FIFO not empty; M_AXIS_DATA = FIFO head; M_AXIS_LAST = VALID && beat_idx==len-1.
  - STREAM: on VALID&&READY the FIFO pops and beat_idx++. On the final beat handshake -> DONE.
  - DONE: done=1 for exactly one cycle, busy=0, -> IDLE.
- Timing and throughput:
  - First VALID is asserted 3 cycles after the edge that samples start.
  - With READY held high, throughput is 1 beat/cycle and no bubbles occur after the first word.
- AXIS rules:
  - Once VALID is asserted, DATA and LAST hold stable until the handshake.
  - VALID never depends combinationally on READY.
- Boundaries:
  - FIFO full plus inflight reads must never overflow; the credit rule guarantees this.
  - start while busy: ignored; the current transfer is unaffected.
  - num_words>MEM_DEPTH: clamped to MEM_DEPTH.
  - len=1: single beat with LAST=1.
  - READY low for N cycles: at most 4 words are buffered and no RAM reads are issued beyond the credit limit.
  - Reset mid-stream: VALID drops immediately (asynchronous), FIFO is flushed, state returns to IDLE, and no done pulse is generated.

Decomposition:
- Shared package matrix_pkg: MATRIX_MEM_DEPTH=1024, MATRIX_MEM_WIDTH=32, derived address width, and the writer state enum (IDLE, STREAM, DONE).
- One sub-module: stream_fifo.
  - Parameterised width and depth (4).
  - Async active-high reset, push/pop/full/empty/count.
  - Simultaneous push and pop when full or empty must be handled correctly.

Test Plan:
- Reset, then start with num_words=4, RAM[i]=0xA000_0000+i, READY=1 -> beats 0xA0000000..0xA0000003 on consecutive cycles; LAST on the 4th only; first VALID 3 cycles after start; done pulses once; busy low afterwards.
- num_words=16 with READY toggling 1,0,0,1 repeating -> all 16 words in order, no duplicates or drops; DATA stable while VALID&&!READY; mem_address never more than 4 ahead of beat_idx.
- num_words=0 -> no VALID ever; done pulses the cycle after start; busy never asserted.
- num_words=1 -> single beat RAM[0] with LAST=1.
- num_words=2000 (clamped) -> exactly 1024 beats, final beat RAM[1023] with LAST; second start during the stream is ignored.
- RESET asserted mid-stream at beat 5 of 10, then start with num_words=3 -> VALID drops asynchronously; new stream emits RAM[0..2] with LAST on RAM[2].
